// File: rtl/mem_request_queue_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package  : mem_req_pkg                                                     |
// | Purpose  : Shared types for the data-memory request queue: request opcode, |
// |            canonical queue entry and controller state encoding.            |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
package mem_req_pkg;

  // Canonical datapath widths; the queue top re-derives its own entry type
  // from its AW/DW parameters so other widths stay lossless.
  localparam int MREQ_ADDR_W = 32;
  localparam int MREQ_DATA_W = 32;

  typedef enum logic {
    MREQ_LD = 1'b0,
    MREQ_ST = 1'b1
  } mreq_op_t;

  typedef struct packed {
    mreq_op_t               op;
    logic [MREQ_ADDR_W-1:0] addr;
    logic [MREQ_DATA_W-1:0] wdata;
  } mreq_entry_t;

  typedef enum logic [1:0] {
    MRQ_IDLE   = 2'd0,
    MRQ_ACTIVE = 2'd1,
    MRQ_ERROR  = 2'd2
  } mreq_state_t;

  // A simultaneous read+write request is treated as a store.
  function automatic mreq_op_t mreq_op_of(input logic wr);
    return wr ? MREQ_ST : MREQ_LD;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_request_queue_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Interface : mem_request_queue_if                                           |
// | Purpose   : Bundles the MEM-stage request side, the memory side and the    |
// |             status flags of mem_request_queue.                             |
// | Ports     : master - MEM stage / memory model (drives requests and dhit)   |
// |             slave  - the queue (drives dREN/dWEN/daddr/dstore and status)  |
// | Revision  : 1.0 - initial release                                          |
// +----------------------------------------------------------------------------+
interface mem_request_queue_if #(
  parameter int AW    = 32,
  parameter int DW    = 32,
  parameter int DEPTH = 4
);
  localparam int c_CW = $clog2(DEPTH) + 1;

  // request side
  logic            advance;
  logic            flush;
  logic            req_rd;
  logic            req_wr;
  logic [AW-1:0]   req_addr;
  logic [DW-1:0]   req_wdata;
  // memory side
  logic            dhit;
  logic            dREN;
  logic            dWEN;
  logic [AW-1:0]   daddr;
  logic [DW-1:0]   dstore;
  // status
  logic            full;
  logic            busy;
  logic [c_CW-1:0] count;
  logic            timeout_err;
  logic            proto_err;

  modport master (
    output advance, flush, req_rd, req_wr, req_addr, req_wdata, dhit,
    input  dREN, dWEN, daddr, dstore, full, busy, count, timeout_err, proto_err
  );

  modport slave (
    input  advance, flush, req_rd, req_wr, req_addr, req_wdata, dhit,
    output dREN, dWEN, daddr, dstore, full, busy, count, timeout_err, proto_err
  );

endinterface
`default_nettype wire

// File: rtl/mem_request_queue_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : mreq_fifo                                                       |
// | Purpose  : Circular request store with wrapping pointers and occupancy     |
// |            count. Exposes the head and the entry behind it so the owner    |
// |            can issue back-to-back. Flush drops everything, or everything   |
// |            except the head when the head is already issued.                |
// | Ports    : CLK, nRST        clock, async active-low reset                  |
// |            push_i/entry_i   write one entry (caller guarantees room)       |
// |            pop_i            retire the head                                |
// |            flush_i          discard entries; keep_head_i spares the head   |
// |            head_o, next_o   entry at read pointer and the one after it     |
// |            count_o, full_o, empty_o  occupancy                             |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module mreq_fifo
  import mem_req_pkg::*;
#(
  parameter int  DEPTH   = 4,
  parameter type ENTRY_T = mreq_entry_t
) (
  input  logic                   CLK,
  input  logic                   nRST,
  input  logic                   push_i,
  input  ENTRY_T                 push_entry_i,
  input  logic                   pop_i,
  input  logic                   flush_i,
  input  logic                   keep_head_i,
  output ENTRY_T                 head_o,
  output ENTRY_T                 next_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   full_o,
  output logic                   empty_o
);

  localparam int c_PW = $clog2(DEPTH);
  localparam int c_CW = c_PW + 1;

  ENTRY_T          mem_q [DEPTH];
  logic [c_PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [c_PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [c_CW-1:0] count_q, count_d;
  logic [c_PW-1:0] w_rd_ptr_nx;

  // DEPTH is a power of two, so plain pointer overflow is the mod-DEPTH wrap.
  assign w_rd_ptr_nx = rd_ptr_q + c_PW'(1);

  always_comb begin
    rd_ptr_d = rd_ptr_q + c_PW'(pop_i);
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      if (keep_head_i && !pop_i) begin
        // issued head cannot be aborted: everything behind it goes
        wr_ptr_d = w_rd_ptr_nx;
        count_d  = c_CW'(1);
      end else begin
        wr_ptr_d = rd_ptr_d;
        count_d  = '0;
      end
    end else begin
      wr_ptr_d = wr_ptr_q + c_PW'(push_i);
      count_d  = count_q + c_CW'(push_i) - c_CW'(pop_i);
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: an entry is only read once count covers it.
  always_ff @(posedge CLK) begin
    if (push_i) begin
      mem_q[wr_ptr_q] <= push_entry_i;
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign next_o  = mem_q[w_rd_ptr_nx];
  assign count_o = count_q;
  assign full_o  = (count_q == c_CW'(DEPTH));
  assign empty_o = (count_q == '0);

endmodule
`default_nettype wire

// File: rtl/mem_request_queue.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : mem_request_queue                                               |
// | Purpose  : Queues up to DEPTH load/store requests from the MEM stage and   |
// |            presents the head to the data memory on registered              |
// |            dREN/dWEN/daddr/dstore until dhit. Supports flush, a wait       |
// |            watchdog (TIMEOUT cycles) and sticky error status.              |
// | Ports    : CLK   clock, rising edge                                        |
// |            nRST  asynchronous active-low reset                             |
// |            bus   mem_request_queue_if.slave: request, memory, status       |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module mem_request_queue
  import mem_req_pkg::*;
#(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                CLK,
  input  logic                nRST,
  mem_request_queue_if.slave  bus
);

  localparam int c_CW = $clog2(DEPTH) + 1;
  localparam int c_WW = $clog2(TIMEOUT + 1);

  typedef struct packed {
    mreq_op_t      op;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } entry_t;

  mreq_state_t     state_q, state_d;
  logic            dren_q, dren_d;
  logic            dwen_q, dwen_d;
  logic [AW-1:0]   daddr_q, daddr_d;
  logic [DW-1:0]   dstore_q, dstore_d;
  logic [c_WW-1:0] wait_q, wait_d;
  logic            proto_q, proto_d;

  entry_t          w_req_entry, w_head, w_next, w_load_entry;
  logic [c_CW-1:0] w_count;
  logic            w_full, w_empty;
  logic            w_pop, w_try, w_push, w_drop, w_load;

  // A request is only considered while the controller is healthy; flush
  // wins over a same-cycle request.
  assign w_pop  = bus.dhit && (state_q == MRQ_ACTIVE);
  assign w_try  = bus.advance && (bus.req_rd || bus.req_wr) &&
                  (state_q != MRQ_ERROR) && !bus.flush;
  // A pop on the same edge frees the slot, so a full queue can still accept.
  assign w_push = w_try && (!w_full || w_pop);
  assign w_drop = w_try && w_full && !w_pop;

  assign w_req_entry = '{op:    mreq_op_of(bus.req_wr),
                         addr:  bus.req_addr,
                         wdata: bus.req_wdata};

  mreq_fifo #(
    .DEPTH   (DEPTH),
    .ENTRY_T (entry_t)
  ) u_fifo (
    .CLK          (CLK),
    .nRST         (nRST),
    .push_i       (w_push),
    .push_entry_i (w_req_entry),
    .pop_i        (w_pop),
    .flush_i      (bus.flush),
    .keep_head_i  (state_q == MRQ_ACTIVE),
    .head_o       (w_head),
    .next_o       (w_next),
    .count_o      (w_count),
    .full_o       (w_full),
    .empty_o      (w_empty)
  );

  always_comb begin
    state_d      = state_q;
    dren_d       = dren_q;
    dwen_d       = dwen_q;
    daddr_d      = daddr_q;
    dstore_d     = dstore_q;
    wait_d       = wait_q;
    w_load       = 1'b0;
    w_load_entry = w_head;

    unique case (state_q)
      MRQ_IDLE: begin
        // flush in IDLE discards the not-yet-issued head, so don't issue it
        if (!w_empty && !bus.flush) begin
          w_load  = 1'b1;
          state_d = MRQ_ACTIVE;
          wait_d  = '0;
        end
      end
      MRQ_ACTIVE: begin
        if (bus.dhit) begin
          wait_d = '0;
          if ((w_count >= c_CW'(2)) && !bus.flush) begin
            // back-to-back: the entry behind the head goes out on this edge
            w_load       = 1'b1;
            w_load_entry = w_next;
          end else begin
            dren_d  = 1'b0;
            dwen_d  = 1'b0;
            state_d = MRQ_IDLE;
          end
        end else if (wait_q == c_WW'(TIMEOUT - 1)) begin
          dren_d  = 1'b0;
          dwen_d  = 1'b0;
          wait_d  = c_WW'(TIMEOUT);
          state_d = MRQ_ERROR;
        end else begin
          wait_d = wait_q + c_WW'(1);
        end
      end
      MRQ_ERROR: begin
        if (bus.flush) begin
          wait_d  = '0;
          state_d = MRQ_IDLE;
        end
      end
      default: state_d = MRQ_IDLE;
    endcase

    if (w_load) begin
      dren_d   = (w_load_entry.op == MREQ_LD);
      dwen_d   = (w_load_entry.op == MREQ_ST);
      daddr_d  = w_load_entry.addr;
      dstore_d = w_load_entry.wdata;
    end
  end

  assign proto_d = proto_q || w_drop || (w_push && bus.req_rd && bus.req_wr);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q  <= MRQ_IDLE;
      dren_q   <= 1'b0;
      dwen_q   <= 1'b0;
      daddr_q  <= '0;
      dstore_q <= '0;
      wait_q   <= '0;
      proto_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      dren_q   <= dren_d;
      dwen_q   <= dwen_d;
      daddr_q  <= daddr_d;
      dstore_q <= dstore_d;
      wait_q   <= wait_d;
      proto_q  <= proto_d;
    end
  end

  assign bus.dREN        = dren_q;
  assign bus.dWEN        = dwen_q;
  assign bus.daddr       = daddr_q;
  assign bus.dstore      = dstore_q;
  assign bus.full        = w_full;
  assign bus.busy        = !w_empty || (state_q != MRQ_IDLE);
  assign bus.count       = w_count;
  assign bus.timeout_err = (state_q == MRQ_ERROR);
  assign bus.proto_err   = proto_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_request_queue.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_mem_request_queue                                            |
// | Purpose  : Self-checking bench for mem_request_queue: cycle vector table   |
// |            plus hand sequences for timeout, flush and reset; issued        |
// |            requests are matched against an in-order expectation queue.     |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_mem_request_queue;

  logic CLK;
  logic nRST;

  mem_request_queue_if #(.AW(32), .DW(32), .DEPTH(4)) bus ();

  mem_request_queue #(
    .AW(32), .DW(32), .DEPTH(4), .TIMEOUT(64)
  ) dut (
    .CLK  (CLK),
    .nRST (nRST),
    .bus  (bus.slave)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // ctl  = {advance, flush, req_rd, req_wr, dhit, accepted}
  // eflg = {dREN, dWEN, full, busy, proto_err} after the edge
  typedef struct {
    logic [5:0]  ctl;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [4:0]  eflg;
    logic [31:0] edaddr;
    logic [2:0]  ecnt;
  } vec_t;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
  } exp_t;

  localparam int NV = 21;
  vec_t vecs [NV];
  exp_t sb [$];
  int   n_pass = 0;
  int   n_tot  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    bus.advance   = 1'b0;
    bus.flush     = 1'b0;
    bus.req_rd    = 1'b0;
    bus.req_wr    = 1'b0;
    bus.dhit      = 1'b0;
    bus.req_addr  = 32'h0;
    bus.req_wdata = 32'h0;
  endtask

  // Drive a request that is expected to be accepted and record it.
  task automatic req(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d);
    exp_t e;
    bus.advance   = 1'b1;
    bus.req_rd    = rd;
    bus.req_wr    = wr;
    bus.req_addr  = a;
    bus.req_wdata = d;
    e.wr = wr; e.addr = a; e.wdata = d;
    sb.push_back(e);
  endtask

  // Compare the currently presented request with the oldest expected one.
  task automatic sb_check(input string nm);
    exp_t e;
    if (sb.size() == 0) begin
      n_tot++;
      $display("FAIL %s sb: dhit with no expected request, got addr 0x%0h", nm, bus.daddr);
    end else begin
      e = sb.pop_front();
      chk({nm, " sb dREN"},  32'(bus.dREN), 32'(!e.wr));
      chk({nm, " sb dWEN"},  32'(bus.dWEN), 32'(e.wr));
      chk({nm, " sb daddr"}, bus.daddr, e.addr);
      if (e.wr) chk({nm, " sb dstore"}, bus.dstore, e.wdata);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{6'b101001, 32'h100, 32'h0,  5'b00010, 32'h0,   3'd1};
    vecs[1]  = '{6'b000000, 32'h0,   32'h0,  5'b10010, 32'h100, 3'd1};
    vecs[2]  = '{6'b000000, 32'h0,   32'h0,  5'b10010, 32'h100, 3'd1};
    vecs[3]  = '{6'b000000, 32'h0,   32'h0,  5'b10010, 32'h100, 3'd1};
    vecs[4]  = '{6'b000010, 32'h0,   32'h0,  5'b00000, 32'h100, 3'd0};
    vecs[5]  = '{6'b100101, 32'h10,  32'hA0, 5'b00010, 32'h100, 3'd1};
    vecs[6]  = '{6'b100101, 32'h14,  32'hA1, 5'b01010, 32'h10,  3'd2};
    vecs[7]  = '{6'b100101, 32'h18,  32'hA2, 5'b01010, 32'h10,  3'd3};
    vecs[8]  = '{6'b000010, 32'h0,   32'h0,  5'b01010, 32'h14,  3'd2};
    vecs[9]  = '{6'b000010, 32'h0,   32'h0,  5'b01010, 32'h18,  3'd1};
    vecs[10] = '{6'b000010, 32'h0,   32'h0,  5'b00000, 32'h18,  3'd0};
    vecs[11] = '{6'b101001, 32'h200, 32'h0,  5'b00010, 32'h18,  3'd1};
    vecs[12] = '{6'b101001, 32'h204, 32'h0,  5'b10010, 32'h200, 3'd2};
    vecs[13] = '{6'b101001, 32'h208, 32'h0,  5'b10010, 32'h200, 3'd3};
    vecs[14] = '{6'b101001, 32'h20C, 32'h0,  5'b10110, 32'h200, 3'd4};
    vecs[15] = '{6'b101000, 32'h210, 32'h0,  5'b10111, 32'h200, 3'd4};
    vecs[16] = '{6'b101011, 32'h214, 32'h0,  5'b10111, 32'h204, 3'd4};
    vecs[17] = '{6'b000010, 32'h0,   32'h0,  5'b10011, 32'h208, 3'd3};
    vecs[18] = '{6'b000010, 32'h0,   32'h0,  5'b10011, 32'h20C, 3'd2};
    vecs[19] = '{6'b000010, 32'h0,   32'h0,  5'b10011, 32'h214, 3'd1};
    vecs[20] = '{6'b000010, 32'h0,   32'h0,  5'b00001, 32'h214, 3'd0};

    nRST = 1'b0;
    idle();
    #12;
    chk("reset dREN",   32'(bus.dREN), 32'h0);
    chk("reset dWEN",   32'(bus.dWEN), 32'h0);
    chk("reset daddr",  bus.daddr, 32'h0);
    chk("reset dstore", bus.dstore, 32'h0);
    chk("reset count",  32'(bus.count), 32'h0);
    chk("reset full",   32'(bus.full), 32'h0);
    chk("reset busy",   32'(bus.busy), 32'h0);
    chk("reset tout",   32'(bus.timeout_err), 32'h0);
    chk("reset proto",  32'(bus.proto_err), 32'h0);
    nRST = 1'b1;

    // ---- vector table: single load, store burst, fill/drop/accept-on-pop
    for (int i = 0; i < NV; i++) begin
      bus.advance   = vecs[i].ctl[5];
      bus.flush     = vecs[i].ctl[4];
      bus.req_rd    = vecs[i].ctl[3];
      bus.req_wr    = vecs[i].ctl[2];
      bus.dhit      = vecs[i].ctl[1];
      bus.req_addr  = vecs[i].addr;
      bus.req_wdata = vecs[i].wdata;
      if (vecs[i].ctl[1]) sb_check($sformatf("r%0d", i));
      if (vecs[i].ctl[0]) begin
        exp_t e;
        e.wr = vecs[i].ctl[2]; e.addr = vecs[i].addr; e.wdata = vecs[i].wdata;
        sb.push_back(e);
      end
      step();
      chk($sformatf("r%0d dREN", i),  32'(bus.dREN),      32'(vecs[i].eflg[4]));
      chk($sformatf("r%0d dWEN", i),  32'(bus.dWEN),      32'(vecs[i].eflg[3]));
      chk($sformatf("r%0d full", i),  32'(bus.full),      32'(vecs[i].eflg[2]));
      chk($sformatf("r%0d busy", i),  32'(bus.busy),      32'(vecs[i].eflg[1]));
      chk($sformatf("r%0d proto", i), 32'(bus.proto_err), 32'(vecs[i].eflg[0]));
      chk($sformatf("r%0d daddr", i), bus.daddr,          vecs[i].edaddr);
      chk($sformatf("r%0d count", i), 32'(bus.count),     32'(vecs[i].ecnt));
    end
    idle();

    // ---- reset clears the sticky protocol error
    nRST = 1'b0;
    #2;
    nRST = 1'b1;
    sb.delete();
    step();
    chk("rst2 proto", 32'(bus.proto_err), 32'h0);

    // ---- watchdog timeout
    req(1'b1, 1'b0, 32'h300, 32'h0);
    step();
    idle();
    step();
    chk("to issue dREN", 32'(bus.dREN), 32'h1);
    chk("to issue daddr", bus.daddr, 32'h300);
    repeat (63) step();
    chk("to 63 dREN", 32'(bus.dREN), 32'h1);
    chk("to 63 tout", 32'(bus.timeout_err), 32'h0);
    step();
    chk("to 64 tout", 32'(bus.timeout_err), 32'h1);
    chk("to 64 dREN", 32'(bus.dREN), 32'h0);
    chk("to 64 busy", 32'(bus.busy), 32'h1);
    bus.dhit = 1'b1;
    step();
    bus.dhit = 1'b0;
    chk("to dhit tout", 32'(bus.timeout_err), 32'h1);
    chk("to dhit count", 32'(bus.count), 32'h1);
    chk("to dhit dREN", 32'(bus.dREN), 32'h0);
    bus.advance = 1'b1; bus.req_rd = 1'b1; bus.req_addr = 32'h304;
    step();
    idle();
    chk("to enq count", 32'(bus.count), 32'h1);
    chk("to enq proto", 32'(bus.proto_err), 32'h0);
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    sb.delete();
    chk("to flush tout", 32'(bus.timeout_err), 32'h0);
    chk("to flush count", 32'(bus.count), 32'h0);
    chk("to flush busy", 32'(bus.busy), 32'h0);
    step();
    chk("to after dREN", 32'(bus.dREN), 32'h0);
    chk("to after busy", 32'(bus.busy), 32'h0);

    // ---- flush while a request is issued keeps only the head
    req(1'b1, 1'b0, 32'h400, 32'h0); step();
    req(1'b1, 1'b0, 32'h404, 32'h0); step();
    req(1'b1, 1'b0, 32'h408, 32'h0); step();
    idle();
    chk("fl pre count", 32'(bus.count), 32'h3);
    chk("fl pre daddr", bus.daddr, 32'h400);
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    void'(sb.pop_back());
    void'(sb.pop_back());
    chk("fl count", 32'(bus.count), 32'h1);
    chk("fl dREN", 32'(bus.dREN), 32'h1);
    chk("fl daddr", bus.daddr, 32'h400);
    bus.dhit = 1'b1;
    sb_check("fl");
    step();
    bus.dhit = 1'b0;
    chk("fl done dREN", 32'(bus.dREN), 32'h0);
    chk("fl done count", 32'(bus.count), 32'h0);
    chk("fl done busy", 32'(bus.busy), 32'h0);
    step();
    chk("fl idle dREN", 32'(bus.dREN), 32'h0);

    // ---- asynchronous reset during an issued store
    req(1'b0, 1'b1, 32'h500, 32'h55);
    step();
    idle();
    step();
    chk("ar pre dWEN", 32'(bus.dWEN), 32'h1);
    #2;
    nRST = 1'b0;
    #1;
    chk("ar dWEN",   32'(bus.dWEN), 32'h0);
    chk("ar dREN",   32'(bus.dREN), 32'h0);
    chk("ar daddr",  bus.daddr, 32'h0);
    chk("ar dstore", bus.dstore, 32'h0);
    chk("ar count",  32'(bus.count), 32'h0);
    chk("ar busy",   32'(bus.busy), 32'h0);
    sb.delete();
    #2;
    nRST = 1'b1;
    req(1'b1, 1'b0, 32'h600, 32'h0);
    step();
    idle();
    step();
    chk("ar new dREN", 32'(bus.dREN), 32'h1);
    chk("ar new daddr", bus.daddr, 32'h600);
    bus.dhit = 1'b1;
    sb_check("ar");
    step();
    bus.dhit = 1'b0;
    chk("ar done dREN", 32'(bus.dREN), 32'h0);
    chk("ar done busy", 32'(bus.busy), 32'h0);

    // ---- read and write together: stored as a store, flagged
    req(1'b1, 1'b1, 32'h700, 32'h77);
    step();
    idle();
    chk("rw proto", 32'(bus.proto_err), 32'h1);
    step();
    chk("rw dWEN", 32'(bus.dWEN), 32'h1);
    chk("rw dREN", 32'(bus.dREN), 32'h0);
    bus.dhit = 1'b1;
    sb_check("rw");
    step();
    bus.dhit = 1'b0;
    chk("rw done dWEN", 32'(bus.dWEN), 32'h0);
    chk("rw done proto", 32'(bus.proto_err), 32'h1);
    chk("sb empty", 32'(sb.size()), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
`default_nettype wire
